// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for EX: shift-add multiply, restoring divide, stall/over handshake.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiplier for MULT/MULTU.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cpu_stall,
   output logic             mult_div_stall,
   output logic             mult_div_over,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state, state_next;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc, acc_step;
   logic [WIDTH-1:0]   opnd_q;
   logic               is_div_q, sign_q, sign_r, div_zero_q;

   logic               signed_op, is_mul;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     rem_shift, diff, sum;
   logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;
   logic [2*WIDTH-1:0] prod;

   assign signed_op = ~op[0];
   assign is_mul    = ~op[1];
   assign mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
   assign mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_mag, fast_prod;
   assign fast_mag  = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
   assign fast_prod = (signed_op && (a[WIDTH-1] ^ b[WIDTH-1])) ? -fast_mag : fast_mag;
`endif

   // Divide keeps {remainder, quotient} in acc; multiply keeps {partial, multiplier}.
   assign rem_shift = acc[2*WIDTH-1:WIDTH-1];
   assign diff      = rem_shift - {1'b0, opnd_q};
   assign sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
   assign acc_step  = is_div_q
                      ? (diff[WIDTH] ? {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                      : {sum, acc[WIDTH-1:1]};

   assign quot   = acc_step[WIDTH-1:0];
   assign rem    = acc_step[2*WIDTH-1:WIDTH];
   assign prod   = sign_q ? -acc_step : acc_step;
   // A zero divisor leaves the dividend magnitude in rem, so sign_r restores a exactly.
   assign res_lo = is_div_q ? (div_zero_q ? '1 : (sign_q ? -quot : quot)) : prod[WIDTH-1:0];
   assign res_hi = is_div_q ? (sign_r ? -rem : rem) : prod[2*WIDTH-1:WIDTH];

   assign mult_div_over  = (state == DONE);
   assign mult_div_stall = start && (state != DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_next and no latch is inferred.
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
`ifdef MULDIV_FAST_MUL_EN
               state_next = is_mul ? DONE : BUSY;
`else
               state_next = BUSY;
`endif
            end
         end
         BUSY: begin
            if (!start)                   state_next = IDLE;
            else if (count == CW'(1))     state_next = DONE;
         end
         DONE: begin
            if (!cpu_stall) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count      <= '0;
         acc        <= '0;
         opnd_q     <= '0;
         is_div_q   <= 1'b0;
         sign_q     <= 1'b0;
         sign_r     <= 1'b0;
         div_zero_q <= 1'b0;
         hi         <= '0;
         lo         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  is_div_q   <= ~is_mul;
                  sign_q     <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                  sign_r     <= signed_op && a[WIDTH-1];
                  div_zero_q <= (b == '0);
                  opnd_q     <= is_mul ? mag_a : mag_b;
                  acc        <= {{WIDTH{1'b0}}, (is_mul ? mag_b : mag_a)};
                  count      <= CW'(WIDTH);
`ifdef MULDIV_FAST_MUL_EN
                  if (is_mul) {hi, lo} <= fast_prod;
`endif
               end
            end
            BUSY: begin
               if (start) begin
                  acc   <= acc_step;
                  count <= count - CW'(1);
                  if (count == CW'(1)) begin
                     hi <= res_hi;
                     lo <= res_lo;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
